// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: pattern mode encoding and the decoder
// that folds the unused mode codes onto OFF.
package led_seq_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 3'd0,
    MODE_STATIC = 3'd1,
    MODE_BLINK  = 3'd2,
    MODE_CHASE  = 3'd3,
    MODE_BOUNCE = 3'd4,
    MODE_COUNT  = 3'd5
  } led_mode_t;

  function automatic led_mode_t decode_mode(input logic [MODE_W-1:0] code);
    led_mode_t m;
    case (code)
      3'd1:    m = MODE_STATIC;
      3'd2:    m = MODE_BLINK;
      3'd3:    m = MODE_CHASE;
      3'd4:    m = MODE_BOUNCE;
      3'd5:    m = MODE_COUNT;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// Global brightness gate: free-running counter compared against the duty value.
// All-ones duty forces the gate permanently open.
module led_pwm_gate #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [PWM_BITS-1:0] i_brightness,
  output logic                o_en
);

  logic [PWM_BITS-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) r_cnt <= '0;
    else         r_cnt <= r_cnt + PWM_BITS'(1);
  end

  assign o_en = (&i_brightness) || (r_cnt < i_brightness);

endmodule

// File: rtl/led_sequencer.sv
// Pattern engine for NUM_LEDS board LEDs: step divider, one-deep config
// handshake applied on step boundaries, pattern state and PWM-gated output.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int STEP_DIV = 10_000_000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [NUM_LEDS-1:0] cfg_pattern,
  input  logic [PWM_BITS-1:0] cfg_brightness,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_tick
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [POS_W-1:0]    LAST_POS  = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    POS_ONE   = POS_W'(1);
  localparam logic [NUM_LEDS-1:0] COUNT_ONE = NUM_LEDS'(1);

  logic [CNT_W-1:0]    r_step_cnt;
  logic                r_pending;
  led_mode_t           r_pend_mode, r_mode;
  logic [NUM_LEDS-1:0] r_pend_pattern, r_pattern;
  logic [PWM_BITS-1:0] r_pend_bright, r_bright;
  logic [POS_W-1:0]    r_pos;
  logic                r_dir_down;
  logic                r_phase;
  logic [NUM_LEDS-1:0] r_count;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_tick, w_accept, w_apply, w_pwm_en;
  logic [NUM_LEDS-1:0] w_raw;

  assign w_tick    = (r_step_cnt == LAST_CNT);
  assign w_accept  = cfg_valid && !r_pending;
  // Pending is only set after the accept edge, so an accept on a tick waits for the next one.
  assign w_apply   = w_tick && r_pending;
  assign cfg_ready = !r_pending;
  assign step_tick = w_tick;
  assign led       = r_led;

  led_pwm_gate #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk          (clk),
    .resetn       (resetn),
    .i_brightness (r_bright),
    .o_en         (w_pwm_en)
  );

  always_comb begin
    // NOTE: default first so no path through the case leaves w_raw unassigned (no latch).
    w_raw = '0;
    case (r_mode)
      MODE_STATIC:             w_raw = r_pattern;
      MODE_BLINK:              w_raw = r_phase ? r_pattern : '0;
      MODE_CHASE, MODE_BOUNCE: w_raw = COUNT_ONE << r_pos;
      MODE_COUNT:              w_raw = r_count;
      default:                 w_raw = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_step_cnt     <= '0;
      r_pending      <= 1'b0;
      r_pend_mode    <= MODE_OFF;
      r_pend_pattern <= '0;
      r_pend_bright  <= '1;
      r_mode         <= MODE_OFF;
      r_pattern      <= '0;
      r_bright       <= '1;
      r_pos          <= '0;
      r_dir_down     <= 1'b0;
      r_phase        <= 1'b1;
      r_count        <= '0;
      r_led          <= '0;
    end else begin
      r_step_cnt <= w_tick ? '0 : r_step_cnt + CNT_ONE;
      r_led      <= w_raw & {NUM_LEDS{w_pwm_en}};

      if (w_accept) begin
        r_pend_mode    <= decode_mode(cfg_mode);
        r_pend_pattern <= cfg_pattern;
        r_pend_bright  <= cfg_brightness;
        r_pending      <= 1'b1;
      end

      if (w_apply) begin
        r_mode     <= r_pend_mode;
        r_pattern  <= r_pend_pattern;
        r_bright   <= r_pend_bright;
        r_pos      <= '0;
        r_dir_down <= 1'b0;
        r_phase    <= 1'b1;
        r_count    <= '0;
        r_pending  <= 1'b0;
      end else if (w_tick) begin
        case (r_mode)
          MODE_BLINK: r_phase <= !r_phase;
          MODE_CHASE: r_pos <= (r_pos == LAST_POS) ? '0 : r_pos + POS_ONE;
          MODE_BOUNCE: begin
            if (NUM_LEDS > 1) begin
              if (r_dir_down) begin
                r_pos <= r_pos - POS_ONE;
                if (r_pos == POS_ONE) r_dir_down <= 1'b0;
              end else begin
                r_pos <= r_pos + POS_ONE;
                if (r_pos == LAST_POS - POS_ONE) r_dir_down <= 1'b1;
              end
            end
          end
          MODE_COUNT: r_count <= r_count + COUNT_ONE;
          default: ;
        endcase
      end
    end
  end

endmodule
